// File: rtl/if_fetch_unit_pkg.sv
// Shared bus widths, constants and state encoding for the RV32I
// instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int MemDataBus  = 8;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;
  localparam logic True_v  = 1'b1;
  localparam logic False_v = 1'b0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetchState_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, pulls four bytes through the MCU
// and presents a little-endian 32-bit instruction to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                BYTE_W   = MemDataBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  input  logic                stall_i,
  input  logic                grant_i,
  input  logic [BYTE_W-1:0]   mem_din_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                inst_valid_o,
  output logic [InstBus-1:0]  inst_o,
  output logic [ADDR_W-1:0]   inst_pc_o
);

  fetchState_e              state_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [2:0]               issueIdx_q;
  logic                     pending_q;
  logic [1:0]               pendingIdx_q;
  logic [3:0][BYTE_W-1:0]   byteBuf_q;
  logic                     instValid_q;
  logic [InstBus-1:0]       inst_q;
  logic [ADDR_W-1:0]        instPc_q;

  logic                     issueFire;
  logic [2:0]               issueIdx_d;
  logic [ADDR_W-1:0]        pcInc_d;

  // Request path sees only registered state (plus the global freeze), so a
  // branch arriving this cycle never changes what the MCU is being asked.
  assign mem_req_o  = rdy && (state_q == FETCH) && (issueIdx_q < 3'd4);
  assign mem_addr_o = pc_q + {{(ADDR_W-3){1'b0}}, issueIdx_q};
  assign issueFire  = mem_req_o && grant_i;
  assign issueIdx_d = issueIdx_q + 3'd1;
  assign pcInc_d    = pc_q + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      issueIdx_q   <= '0;
      pending_q    <= False_v;
      pendingIdx_q <= '0;
      byteBuf_q    <= '0;
      instValid_q  <= False_v;
      inst_q       <= ZeroWord;
      instPc_q     <= '0;
    end else if (rdy) begin
      if (branch_flag_i) begin
        // Dropping pending discards whatever byte the old stream returns next.
        pc_q        <= branch_target_i;
        issueIdx_q  <= '0;
        pending_q   <= False_v;
        instValid_q <= False_v;
        state_q     <= FETCH;
      end else begin
        case (state_q)
          FETCH: begin
            if (issueFire) begin
              pending_q    <= True_v;
              pendingIdx_q <= issueIdx_q[1:0];
              issueIdx_q   <= issueIdx_d;
            end else if (pending_q) begin
              pending_q <= False_v;
            end
            if (pending_q) begin
              byteBuf_q[pendingIdx_q] <= mem_din_i;
              if (pendingIdx_q == 2'd3) begin
                inst_q      <= {mem_din_i, byteBuf_q[2], byteBuf_q[1], byteBuf_q[0]};
                instPc_q    <= pc_q;
                instValid_q <= True_v;
                state_q     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall_i) begin
              instValid_q <= False_v;
              pc_q        <= pcInc_d;
              issueIdx_q  <= '0;
              state_q     <= FETCH;
            end
          end
          default: state_q <= FETCH;
        endcase
      end
    end
  end

  assign inst_valid_o = instValid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = instPc_q;

endmodule
